// File: rtl/booth_pkg.sv
// Shared constants, FSM state type and width helper for the sequential Booth multiplier.
package booth_pkg;
    localparam int MCAND_W = 12;
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int prod_w(input int mplr_w);
        return MCAND_W + mplr_w;
    endfunction
endpackage

// File: rtl/booth_seq_multiplier_slice.sv
// 12-bit signed x 4-bit unsigned radix-4 Booth slice, purely combinational, 16-bit signed result.
module booth_slice_u4
    import booth_pkg::*;
(
    input  logic [MCAND_W-1:0] mcand,
    input  logic [SLICE_W-1:0] sel,
    output logic [15:0]        prod
);
    logic [15:0] m_ext;
    logic [2:0]  trip0, trip1;
    logic        neg0, neg1, one0, one1, two0, two1;
    logic [15:0] mag0, mag1, pp0, pp1, corr;

    always_comb begin
        // Partial products are carried at the full 16-bit result width, so no
        // separate sign-extension bits are needed on top of the operands.
        m_ext = {{4{mcand[MCAND_W-1]}}, mcand};
        trip0 = {sel[1:0], 1'b0};
        trip1 = sel[3:1];

        neg0 = trip0[2] & ~(trip0[1] & trip0[0]);
        one0 = trip0[1] ^ trip0[0];
        two0 = (trip0[2] & ~trip0[1] & ~trip0[0]) | (~trip0[2] & trip0[1] & trip0[0]);
        neg1 = trip1[2] & ~(trip1[1] & trip1[0]);
        one1 = trip1[1] ^ trip1[0];
        two1 = (trip1[2] & ~trip1[1] & ~trip1[0]) | (~trip1[2] & trip1[1] & trip1[0]);

        mag0 = one0 ? m_ext : (two0 ? (m_ext << 1) : 16'd0);
        mag1 = one1 ? m_ext : (two1 ? (m_ext << 1) : 16'd0);
        // Negated digits are inverted here and completed by the +1 carries below.
        pp0  = mag0 ^ {16{neg0}};
        pp1  = mag1 ^ {16{neg1}};
        // The top Booth digit reads sel[3] as -8; adding 16*mcand restores the unsigned weight.
        corr = sel[3] ? (m_ext << 4) : 16'd0;

        prod = pp0 + (pp1 << 2) + corr + {15'd0, neg0} + {13'd0, neg1, 2'd0};
    end
endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed x unsigned multiplier: one 4-bit Booth slice per cycle, early exit on zero upper bits.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int MPLR_W = 16,
    parameter int PROD_W = prod_w(MPLR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_mcand,
    input  logic [MPLR_W-1:0] in_mplr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic              busy,
    output state_t            dbg_state
);
    localparam int NSLICE = MPLR_W / SLICE_W;
    localparam int K_W    = $clog2(NSLICE) + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // producer holds valid and its data stable until that edge, ready may move freely.

    state_t                    state, state_nxt;
    logic [MCAND_W-1:0]        mcand_r;
    logic [MPLR_W-1:0]         mplr_sr;
    logic [K_W-1:0]            k;
    logic signed [PROD_W-1:0]  acc;
    logic signed [15:0]        p;
    logic signed [PROD_W-1:0]  p_ext;
    logic                      last_slice;

    booth_slice_u4 u_slice (
        .mcand (mcand_r),
        .sel   (mplr_sr[SLICE_W-1:0]),
        .prod  (p)
    );

    assign p_ext      = PROD_W'(p);
    assign last_slice = ((mplr_sr >> SLICE_W) == '0) || (k == K_W'(NSLICE - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = BUSY;
            BUSY:    if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand_r <= '0;
            mplr_sr <= '0;
            k       <= '0;
            acc     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand_r <= in_mcand;
                        mplr_sr <= in_mplr;
                        acc     <= '0;
                        k       <= '0;
                    end
                end
                BUSY: begin
                    acc     <= acc + (p_ext << (SLICE_W * k));
                    mplr_sr <= mplr_sr >> SLICE_W;
                    k       <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_prod  = acc;
    assign dbg_state = state;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: directed vectors, backpressure, async reset, random regression.
module tb_booth_seq_multiplier;
    import booth_pkg::*;

    localparam int MPLR_W  = 16;
    localparam int PROD_W  = prod_w(MPLR_W);
    localparam int NSLICE  = MPLR_W / 4;
    localparam int MAX_LAT = NSLICE + 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [11:0]       in_mcand = '0;
    logic [MPLR_W-1:0] in_mplr = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PROD_W-1:0] out_prod;
    logic              busy;
    state_t            dbg_state;

    logic [11:0]       s_mc = '0;
    logic [3:0]        s_sel = '0;
    logic [15:0]       s_prod;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_seq_multiplier #(.MPLR_W(MPLR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mcand  (in_mcand),
        .in_mplr   (in_mplr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    booth_slice_u4 u_slice_alone (
        .mcand (s_mc),
        .sel   (s_sel),
        .prod  (s_prod)
    );

    // Reference model: exact signed x unsigned product and latency from nibble count.
    function automatic logic [PROD_W-1:0] ref_prod(input logic [11:0] mc, input logic [MPLR_W-1:0] mp);
        longint prod;
        prod = longint'($signed(mc)) * longint'(mp);
        return prod[PROD_W-1:0];
    endfunction

    function automatic int ref_lat(input logic [MPLR_W-1:0] mp);
        int n;
        n = 1;
        for (int i = 1; i < NSLICE; i++)
            if ((mp >> (4 * i)) != 0) n = i + 1;
        return n + 1;
    endfunction

    // Driver: one transaction from capture to hand-off; returns observations only.
    task automatic drive_txn(input logic [11:0] mc, input logic [MPLR_W-1:0] mp, input int stall,
                             output logic [PROD_W-1:0] prod, output int lat,
                             output bit stable, output bit back_idle);
        stable    = 1'b1;
        back_idle = 1'b0;
        prod      = '0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_mcand  = mc;
        in_mplr   = mp;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_mcand  = 12'($urandom);
        in_mplr   = MPLR_W'($urandom);
        lat = 1;
        while (!out_valid && lat < MAX_LAT) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            lat = -1;
            out_ready = 1'b1;
            return;
        end
        prod = out_prod;
        for (int s = 0; s < stall; s++) begin
            if (out_valid !== 1'b1 || out_prod !== prod || in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
            @(posedge clk); #1;
        end
        if (out_valid !== 1'b1 || out_prod !== prod || in_ready !== 1'b0) stable = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        back_idle = (out_valid === 1'b0 && in_ready === 1'b1 && busy === 1'b0);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_prod !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: in_ready=%b out_valid=%b out_prod=%h busy=%b, want 1 0 0 0",
                     in_ready, out_valid, out_prod, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dbg_state !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: state=%0d in_ready=%b out_valid=%b busy=%b, want IDLE 1 0 0",
                     dbg_state, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_slice();
        int exp;
        for (int m = 0; m < 4096; m++) begin
            for (int s = 0; s < 16; s++) begin
                s_mc  = 12'(m);
                s_sel = 4'(s);
                #1;
                exp = int'($signed(s_mc)) * s;
                n_checks++;
                if (s_prod !== exp[15:0]) begin
                    n_errors++;
                    if (n_errors < 20)
                        $display("FAIL slice %h*%h: got %h want %h", s_mc, s_sel, s_prod, exp[15:0]);
                end
            end
        end
    endtask

    task automatic test_directed();
        logic [11:0]       mc_t[5]  = '{12'h800, 12'h7FF, 12'h123, 12'h000, 12'hFFF};
        logic [MPLR_W-1:0] mp_t[5]  = '{16'hFFFF, 16'h0003, 16'h0000, 16'h0F00, 16'h8001};
        logic [PROD_W-1:0] exp_t[5] = '{28'h8000800, 28'h00017FD, 28'h0, 28'h0, 28'hFFF7FFF};
        int                lat_t[5] = '{5, 2, 2, 4, 5};
        int                stl_t[5] = '{0, 0, 0, 1, 5};
        logic [PROD_W-1:0] prod;
        int lat;
        bit stable, idle;
        for (int i = 0; i < 5; i++) begin
            drive_txn(mc_t[i], mp_t[i], stl_t[i], prod, lat, stable, idle);
            n_checks++;
            if (prod !== exp_t[i]) begin
                n_errors++;
                $display("FAIL directed_prod[%0d]: got %h want %h", i, prod, exp_t[i]);
            end
            n_checks++;
            if (lat != lat_t[i]) begin
                n_errors++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, lat_t[i]);
            end
            n_checks++;
            if (!stable || !idle) begin
                n_errors++;
                $display("FAIL directed_handshake[%0d]: stable=%b idle_after=%b, want 1 1", i, stable, idle);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [PROD_W-1:0] prod;
        int lat;
        bit stable, idle;
        @(negedge clk);
        in_valid = 1'b1;
        in_mcand = 12'h555;
        in_mplr  = 16'hABCD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_prod !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_busy: in_ready=%b out_valid=%b out_prod=%h busy=%b, want 1 0 0 0",
                     in_ready, out_valid, out_prod, busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_txn(12'h001, 16'h0010, 0, prod, lat, stable, idle);
        n_checks++;
        if (prod !== 28'h0000010 || lat != 3) begin
            n_errors++;
            $display("FAIL after_reset_txn: prod=%h lat=%0d, want 0000010 3", prod, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [PROD_W-1:0] prod;
        int lat;
        bit stable, idle;
        realtime t0, t1;
        t0 = $realtime;
        drive_txn(12'h00F, 16'h0021, 0, prod, lat, stable, idle);
        drive_txn(12'hF00, 16'h0005, 0, prod, lat, stable, idle);
        t1 = $realtime;
        n_checks++;
        if (prod !== ref_prod(12'hF00, 16'h0005) || !idle) begin
            n_errors++;
            $display("FAIL back_to_back: prod=%h idle_after=%b, want %h 1", prod, idle, ref_prod(12'hF00, 16'h0005));
        end
        // Two transfers of n=2 and n=1 need 4 + 3 cycles at minimum initiation interval.
        n_checks++;
        if (t1 - t0 > 90.0) begin
            n_errors++;
            $display("FAIL back_to_back_rate: took %0t, want at most 90", t1 - t0);
        end
    endtask

    task automatic test_random();
        logic [11:0]       mc;
        logic [MPLR_W-1:0] mp;
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] exp_q[$];
        int lat_q[$];
        int lat, stall;
        bit stable, idle;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       mc = 12'h800;
                1:       mc = 12'h7FF;
                2:       mc = 12'h000;
                default: mc = 12'($urandom);
            endcase
            mp    = MPLR_W'($urandom) >> $urandom_range(0, MPLR_W);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            exp_q.push_back(ref_prod(mc, mp));
            lat_q.push_back(ref_lat(mp));
            drive_txn(mc, mp, stall, prod, lat, stable, idle);
            n_checks++;
            if (prod !== exp_q[0] || lat != lat_q[0] || !stable || !idle) begin
                n_errors++;
                if (n_errors < 20)
                    $display("FAIL random[%0d] %h*%h: prod=%h lat=%0d stable=%b idle=%b, want %h %0d 1 1",
                             i, mc, mp, prod, lat, stable, idle, exp_q[0], lat_q[0]);
            end
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_slice();
        test_directed();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
